// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache miss-status controller.
// Holds the MSHR entry layout and the memory bus command encodings.
package dcache_pkg;

    localparam int unsigned NUM_WAYS      = 4;
    localparam int unsigned NUM_SET_BITS  = $clog2(32 / NUM_WAYS);
    localparam int unsigned NUM_TAG_BITS  = 13 - NUM_SET_BITS;
    localparam int unsigned NUM_MSHR      = 4;
    localparam int unsigned MEM_TAG_BITS  = 4;
    localparam int unsigned MSHR_PTR_BITS = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } mshr_state_t;

    typedef struct packed {
        mshr_state_t               state;
        logic [NUM_TAG_BITS-1:0]   tag;
        logic [NUM_SET_BITS-1:0]   index;
        logic [MEM_TAG_BITS-1:0]   mem_tag;
    } mshr_entry_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: grants the first set request bit at or after ptr,
// wrapping around, as a one-hot vector plus a valid flag.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!valid && req[j] && (j == (i + 32'(ptr)) % N)) begin
                    gnt[j] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss-status controller: allocates/merges load misses into MSHRs,
// issues BUS_LOAD requests round-robin and turns tagged responses into fills.
module dcache_miss_ctrl
    import dcache_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     miss_valid,
    input  logic [NUM_SET_BITS-1:0]  miss_index,
    input  logic [NUM_TAG_BITS-1:0]  miss_tag,
    output logic                     miss_ready,
    output logic [1:0]               proc2mem_command,
    output logic [63:0]              proc2mem_addr,
    input  logic [MEM_TAG_BITS-1:0]  mem2proc_response,
    input  logic [MEM_TAG_BITS-1:0]  mem2proc_tag,
    input  logic [63:0]              mem2proc_data,
    output logic                     fill_valid,
    output logic [NUM_SET_BITS-1:0]  fill_index,
    output logic [NUM_TAG_BITS-1:0]  fill_tag,
    output logic [63:0]              fill_data,
    output logic [NUM_MSHR-1:0]      mshr_busy
);

    localparam int unsigned ADDR_PAD = 64 - NUM_TAG_BITS - NUM_SET_BITS;

    mshr_entry_t [NUM_MSHR-1:0]  entries_q, entries_d;
    logic [MSHR_PTR_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic                        fill_valid_q, fill_valid_d;
    logic [NUM_SET_BITS-1:0]     fill_index_q, fill_index_d;
    logic [NUM_TAG_BITS-1:0]     fill_tag_q, fill_tag_d;
    logic [63:0]                 fill_data_q, fill_data_d;

    logic [NUM_MSHR-1:0]         pend_vec;
    logic [NUM_MSHR-1:0]         issue_gnt;
    logic                        issue_vld;
    logic [MSHR_PTR_BITS-1:0]    issue_idx;
    logic [MSHR_PTR_BITS-1:0]    alloc_idx;
    logic                        merge_hit;
    logic                        any_idle;

    // Merge and alloc look only at registered state, so a slot freed by a
    // completion this cycle is neither merge-blocking afterwards nor reusable yet.
    always_comb begin : status
        pend_vec  = '0;
        mshr_busy = '0;
        merge_hit = 1'b0;
        any_idle  = 1'b0;
        alloc_idx = '0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            pend_vec[i]  = (entries_q[i].state == PEND);
            mshr_busy[i] = (entries_q[i].state != IDLE);
            if (entries_q[i].state != IDLE && entries_q[i].tag == miss_tag &&
                entries_q[i].index == miss_index) begin
                merge_hit = 1'b1;
            end
            if (entries_q[i].state == IDLE && !any_idle) begin
                any_idle  = 1'b1;
                alloc_idx = MSHR_PTR_BITS'(i);
            end
        end
        miss_ready = merge_hit | any_idle;
    end

    rr_pick #(
        .N (NUM_MSHR)
    ) u_rr_pick (
        .req   (pend_vec),
        .ptr   (rr_ptr_q),
        .gnt   (issue_gnt),
        .valid (issue_vld)
    );

    // Bus address is the zero-extended {tag,index} block address.
    always_comb begin : issue_mux
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        issue_idx        = '0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (issue_vld && issue_gnt[i]) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {{ADDR_PAD{1'b0}}, entries_q[i].tag, entries_q[i].index};
                issue_idx        = MSHR_PTR_BITS'(i);
            end
        end
    end

    always_comb begin : next_state
        entries_d    = entries_q;
        rr_ptr_d     = rr_ptr_q;
        fill_valid_d = 1'b0;
        fill_index_d = fill_index_q;
        fill_tag_d   = fill_tag_q;
        fill_data_d  = fill_data_q;

        if (miss_valid && !merge_hit && any_idle) begin
            entries_d[alloc_idx].state   = PEND;
            entries_d[alloc_idx].tag     = miss_tag;
            entries_d[alloc_idx].index   = miss_index;
            entries_d[alloc_idx].mem_tag = '0;
        end

        if (issue_vld && mem2proc_response != '0) begin
            entries_d[issue_idx].state   = ISSUED;
            entries_d[issue_idx].mem_tag = mem2proc_response;
            rr_ptr_d = MSHR_PTR_BITS'((32'(issue_idx) + 1) % NUM_MSHR);
        end

        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (mem2proc_tag != '0 && entries_q[i].state == ISSUED &&
                entries_q[i].mem_tag == mem2proc_tag) begin
                entries_d[i].state = IDLE;
                fill_valid_d       = 1'b1;
                fill_index_d       = entries_q[i].index;
                fill_tag_d         = entries_q[i].tag;
                fill_data_d        = mem2proc_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q    <= '0;
            rr_ptr_q     <= '0;
            fill_valid_q <= 1'b0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            fill_data_q  <= '0;
        end else begin
            entries_q    <= entries_d;
            rr_ptr_q     <= rr_ptr_d;
            fill_valid_q <= fill_valid_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_index = fill_index_q;
    assign fill_tag   = fill_tag_q;
    assign fill_data  = fill_data_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed self-checking bench for dcache_miss_ctrl.
module tb_dcache_miss_ctrl;

    localparam logic [1:0] CMD_NONE = 2'h0;
    localparam logic [1:0] CMD_LOAD = 2'h1;

    logic        clock;
    logic        reset;
    logic        miss_valid;
    logic [2:0]  miss_index;
    logic [9:0]  miss_tag;
    logic        miss_ready;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        fill_valid;
    logic [2:0]  fill_index;
    logic [9:0]  fill_tag;
    logic [63:0] fill_data;
    logic [3:0]  mshr_busy;

    int n_checks;
    int n_fails;

    dcache_miss_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .miss_valid        (miss_valid),
        .miss_index        (miss_index),
        .miss_tag          (miss_tag),
        .miss_ready        (miss_ready),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .fill_valid        (fill_valid),
        .fill_index        (fill_index),
        .fill_tag          (fill_tag),
        .fill_data         (fill_data),
        .mshr_busy         (mshr_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; miss_valid = 1'b0; miss_index = '0; miss_tag = '0;
        mem2proc_response = '0; mem2proc_tag = 4'd3; mem2proc_data = 64'h55;
        repeat (3) tick();
        n_checks++; if (fill_valid !== 1'b0) begin n_fails++; $display("FAIL rst_fill_valid: got %b want 0", fill_valid); end
        n_checks++; if (mshr_busy !== 4'b0000) begin n_fails++; $display("FAIL rst_busy: got %b want 0000", mshr_busy); end
        n_checks++; if (proc2mem_command !== CMD_NONE) begin n_fails++; $display("FAIL rst_cmd: got %h want %h", proc2mem_command, CMD_NONE); end
        n_checks++; if (proc2mem_addr !== 64'h0) begin n_fails++; $display("FAIL rst_addr: got %h want 0", proc2mem_addr); end
        n_checks++; if (fill_data !== 64'h0 || fill_tag !== 10'h0 || fill_index !== 3'h0) begin n_fails++; $display("FAIL rst_fill_fields: got %h/%h/%h want 0", fill_index, fill_tag, fill_data); end
        reset = 1'b1;
        tick();
        mem2proc_tag = '0;
        tick();
        n_checks++; if (fill_valid !== 1'b0 || mshr_busy !== 4'b0000 || proc2mem_command !== CMD_NONE) begin n_fails++; $display("FAIL post_rst_idle: got fv=%b busy=%b cmd=%h want 0/0000/0", fill_valid, mshr_busy, proc2mem_command); end
    endtask

    task automatic test_single_miss();
        miss_valid = 1'b1; miss_index = 3'b110; miss_tag = 10'h009;
        #1;
        n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL single_ready: got %b want 1", miss_ready); end
        tick();
        miss_valid = 1'b0;
        #1;
        n_checks++; if (proc2mem_command !== CMD_LOAD || proc2mem_addr !== 64'h04E) begin n_fails++; $display("FAIL single_issue: got cmd=%h addr=%h want 1/04e", proc2mem_command, proc2mem_addr); end
        n_checks++; if (mshr_busy !== 4'b0001) begin n_fails++; $display("FAIL single_busy_pend: got %b want 0001", mshr_busy); end
        mem2proc_response = 4'd2;
        tick();
        mem2proc_response = '0;
        #1;
        n_checks++; if (proc2mem_command !== CMD_NONE || mshr_busy !== 4'b0001) begin n_fails++; $display("FAIL single_issued: got cmd=%h busy=%b want 0/0001", proc2mem_command, mshr_busy); end
        mem2proc_tag = 4'd2; mem2proc_data = 64'hFFFF_FFFF_FFFF_FFF1;
        #1;
        n_checks++; if (fill_valid !== 1'b0) begin n_fails++; $display("FAIL single_fill_early: got %b want 0", fill_valid); end
        tick();
        mem2proc_tag = '0; mem2proc_data = '0;
        #1;
        n_checks++; if (fill_valid !== 1'b1 || fill_index !== 3'b110 || fill_tag !== 10'h009) begin n_fails++; $display("FAIL single_fill: got fv=%b idx=%b tag=%h want 1/110/009", fill_valid, fill_index, fill_tag); end
        n_checks++; if (fill_data !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fails++; $display("FAIL single_fill_data: got %h want fffffffffffffff1", fill_data); end
        n_checks++; if (mshr_busy !== 4'b0000) begin n_fails++; $display("FAIL single_freed: got %b want 0000", mshr_busy); end
        tick();
        n_checks++; if (fill_valid !== 1'b0) begin n_fails++; $display("FAIL single_fill_pulse: got %b want 0", fill_valid); end
    endtask

    task automatic test_issue_retry();
        miss_valid = 1'b1; miss_index = 3'd2; miss_tag = 10'h155;
        tick();
        miss_valid = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            mem2proc_response = (c == 3) ? 4'd5 : 4'd0;
            #1;
            n_checks++; if (proc2mem_command !== CMD_LOAD || proc2mem_addr !== 64'hAAA) begin n_fails++; $display("FAIL retry_issue_%0d: got cmd=%h addr=%h want 1/aaa", c, proc2mem_command, proc2mem_addr); end
            tick();
        end
        mem2proc_response = '0;
        #1;
        n_checks++; if (proc2mem_command !== CMD_NONE || mshr_busy !== 4'b0001) begin n_fails++; $display("FAIL retry_issued: got cmd=%h busy=%b want 0/0001", proc2mem_command, mshr_busy); end
        mem2proc_tag = 4'd7; mem2proc_data = 64'hBAD;
        tick();
        n_checks++; if (fill_valid !== 1'b0 || mshr_busy !== 4'b0001) begin n_fails++; $display("FAIL retry_nonmatch: got fv=%b busy=%b want 0/0001", fill_valid, mshr_busy); end
        mem2proc_tag = 4'd5; mem2proc_data = 64'h1234;
        tick();
        mem2proc_tag = '0;
        n_checks++; if (fill_valid !== 1'b1 || fill_tag !== 10'h155 || fill_index !== 3'd2 || fill_data !== 64'h1234) begin n_fails++; $display("FAIL retry_fill: got fv=%b tag=%h idx=%h data=%h want 1/155/2/1234", fill_valid, fill_tag, fill_index, fill_data); end
        tick();
    endtask

    task automatic test_merge();
        int          loads_a;
        int          loads_total;
        logic [63:0] first_addr;
        loads_a = 0; loads_total = 0; first_addr = '0;
        miss_valid = 1'b1; miss_index = 3'd1; miss_tag = 10'h0A1;
        #1;
        n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL merge_ready_a: got %b want 1", miss_ready); end
        tick();
        #1;
        n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL merge_ready_repeat: got %b want 1", miss_ready); end
        tick();
        miss_index = 3'd4; miss_tag = 10'h0B2;
        tick();
        miss_valid = 1'b0;
        n_checks++; if (mshr_busy !== 4'b0011) begin n_fails++; $display("FAIL merge_busy: got %b want 0011", mshr_busy); end
        for (int unsigned k = 0; k < 3; k++) begin
            mem2proc_response = 4'(8 + k);
            #1;
            if (proc2mem_command === CMD_LOAD) begin
                if (loads_total == 0) first_addr = proc2mem_addr;
                loads_total++;
                if (proc2mem_addr === 64'h509) loads_a++;
            end
            tick();
        end
        mem2proc_response = '0;
        n_checks++; if (loads_a !== 1) begin n_fails++; $display("FAIL merge_loads_a: got %0d want 1", loads_a); end
        n_checks++; if (loads_total !== 2 || first_addr !== 64'h594) begin n_fails++; $display("FAIL merge_loads_total: got %0d first=%h want 2/594", loads_total, first_addr); end
        miss_valid = 1'b1; miss_index = 3'd1; miss_tag = 10'h0A1;
        mem2proc_tag = 4'd9; mem2proc_data = 64'hA;
        #1;
        n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL merge_completing_ready: got %b want 1", miss_ready); end
        tick();
        miss_valid = 1'b0; mem2proc_tag = 4'd8; mem2proc_data = 64'hB;
        n_checks++; if (fill_valid !== 1'b1 || fill_tag !== 10'h0A1 || mshr_busy !== 4'b0010) begin n_fails++; $display("FAIL merge_completing_fill: got fv=%b tag=%h busy=%b want 1/0a1/0010", fill_valid, fill_tag, mshr_busy); end
        tick();
        mem2proc_tag = '0;
        n_checks++; if (fill_valid !== 1'b1 || fill_tag !== 10'h0B2 || fill_index !== 3'd4 || mshr_busy !== 4'b0000) begin n_fails++; $display("FAIL merge_fill_b: got fv=%b tag=%h idx=%h busy=%b want 1/0b2/4/0000", fill_valid, fill_tag, fill_index, mshr_busy); end
        tick();
    endtask

    task automatic test_full_table();
        logic [63:0] exp_addr [4];
        exp_addr[0] = 64'h809; exp_addr[1] = 64'h812; exp_addr[2] = 64'h81B; exp_addr[3] = 64'h800;
        for (int unsigned k = 0; k < 4; k++) begin
            miss_valid = 1'b1; miss_index = 3'(k); miss_tag = 10'(32'h100 + k);
            #1;
            n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL full_alloc_ready_%0d: got %b want 1", k, miss_ready); end
            tick();
        end
        miss_index = 3'd7; miss_tag = 10'h3FF;
        #1;
        n_checks++; if (miss_ready !== 1'b0 || mshr_busy !== 4'b1111) begin n_fails++; $display("FAIL full_reject: got ready=%b busy=%b want 0/1111", miss_ready, mshr_busy); end
        for (int unsigned k = 0; k < 4; k++) begin
            mem2proc_response = 4'(k + 1);
            #1;
            n_checks++; if (proc2mem_addr !== exp_addr[k] || miss_ready !== 1'b0) begin n_fails++; $display("FAIL full_issue_%0d: got addr=%h ready=%b want %h/0", k, proc2mem_addr, miss_ready, exp_addr[k]); end
            tick();
        end
        mem2proc_response = '0;
        mem2proc_tag = 4'd2; mem2proc_data = 64'hDEAD_BEEF_0000_0002;
        #1;
        n_checks++; if (miss_ready !== 1'b0) begin n_fails++; $display("FAIL full_freeing_ready: got %b want 0", miss_ready); end
        tick();
        mem2proc_tag = '0;
        n_checks++; if (fill_valid !== 1'b1 || fill_index !== 3'd2 || fill_tag !== 10'h102 || fill_data !== 64'hDEAD_BEEF_0000_0002) begin n_fails++; $display("FAIL full_fill2: got fv=%b idx=%h tag=%h data=%h want 1/2/102/deadbeef00000002", fill_valid, fill_index, fill_tag, fill_data); end
        n_checks++; if (miss_ready !== 1'b1) begin n_fails++; $display("FAIL full_ready_after_free: got %b want 1", miss_ready); end
        tick();
        miss_valid = 1'b0;
        #1;
        n_checks++; if (mshr_busy !== 4'b1111 || proc2mem_command !== CMD_LOAD || proc2mem_addr !== 64'h1FFF) begin n_fails++; $display("FAIL full_fifth_alloc: got busy=%b cmd=%h addr=%h want 1111/1/1fff", mshr_busy, proc2mem_command, proc2mem_addr); end
        mem2proc_response = 4'd6;
        tick();
        mem2proc_response = '0;
        mem2proc_tag = 4'd6; mem2proc_data = 64'h6;
        tick();
        mem2proc_tag = '0;
        n_checks++; if (fill_index !== 3'd7 || fill_tag !== 10'h3FF || mshr_busy !== 4'b1011) begin n_fails++; $display("FAIL full_fifth_in_entry2: got idx=%h tag=%h busy=%b want 7/3ff/1011", fill_index, fill_tag, mshr_busy); end
        for (int unsigned k = 0; k < 3; k++) begin
            mem2proc_tag = (k == 0) ? 4'd1 : ((k == 1) ? 4'd3 : 4'd4);
            tick();
        end
        mem2proc_tag = '0;
        n_checks++; if (mshr_busy !== 4'b0000) begin n_fails++; $display("FAIL full_drain: got %b want 0000", mshr_busy); end
        tick();
    endtask

    task automatic test_reset_inflight();
        miss_valid = 1'b1; miss_index = 3'd5; miss_tag = 10'h0C0;
        tick();
        miss_tag = 10'h0C1;
        tick();
        miss_valid = 1'b0;
        mem2proc_response = 4'd10;
        tick();
        mem2proc_response = 4'd11;
        tick();
        mem2proc_response = '0;
        #1;
        n_checks++; if (mshr_busy !== 4'b0011 || proc2mem_command !== CMD_NONE) begin n_fails++; $display("FAIL inflight_issued: got busy=%b cmd=%h want 0011/0", mshr_busy, proc2mem_command); end
        reset = 1'b0;
        #1;
        n_checks++; if (mshr_busy !== 4'b0000 || proc2mem_command !== CMD_NONE) begin n_fails++; $display("FAIL inflight_async_rst: got busy=%b cmd=%h want 0000/0", mshr_busy, proc2mem_command); end
        tick();
        reset = 1'b1;
        mem2proc_tag = 4'd10; mem2proc_data = 64'hA;
        tick();
        n_checks++; if (fill_valid !== 1'b0) begin n_fails++; $display("FAIL inflight_drop10: got %b want 0", fill_valid); end
        mem2proc_tag = 4'd11;
        tick();
        mem2proc_tag = '0;
        n_checks++; if (fill_valid !== 1'b0 || mshr_busy !== 4'b0000) begin n_fails++; $display("FAIL inflight_drop11: got fv=%b busy=%b want 0/0000", fill_valid, mshr_busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_single_miss();
        test_issue_retry();
        test_merge();
        test_full_table();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
